distributor: RTL

Downstream counterpart of the byte-to-word packer. Takes 64-bit packet words with a per-word code and a valid-byte count, and serializes them into a byte stream carrying per-byte SOP/DATA/EOP/BADEOP codes. Both sides use the srdy/drdy handshake. It sits between the packet FIFO output and the byte-wide egress port.

---
 rtl/distributor.sv | 110 +++++++++++
 1 files changed

// File: rtl/distributor.sv
// Packet word to byte stream serializer: unpacks 64-bit packet words into bytes
// tagged with SOP/DATA/EOP/BADEOP, using srdy/drdy handshakes on both sides.
module distributor #(
    parameter int PFW_SZ = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_srdy,
    input  logic [PFW_SZ-1:0] p_data,
    input  logic [1:0]        p_code,
    input  logic [2:0]        p_vbytes,
    output logic              p_drdy,
    output logic              c_srdy,
    output logic [7:0]        c_data,
    output logic [1:0]        c_code,
    input  logic              c_drdy
);

    localparam logic [1:0] PCC_DATA   = 2'd0;
    localparam logic [1:0] PCC_SOP    = 2'd1;
    localparam logic [1:0] PCC_EOP    = 2'd2;
    localparam logic [1:0] PCC_BADEOP = 2'd3;

    logic [PFW_SZ-1:0] hold_data_q, hold_data_d;
    logic [1:0]        hold_code_q, hold_code_d;
    logic [2:0]        last_idx_q, last_idx_d;
    logic              word_vld_q, word_vld_d;
    logic [2:0]        idx_q, idx_d;
    logic              in_pkt_q, in_pkt_d;
    logic              first_q, first_d;

    logic              last_hit;
    logic              word_xfer;
    logic              final_word;
    logic [PFW_SZ-1:0] shifted;

    always_comb begin
        last_hit   = (idx_q == last_idx_q);
        final_word = (hold_code_q == PCC_EOP) || (hold_code_q == PCC_BADEOP);
        shifted    = hold_data_q << {idx_q, 3'b000};

        p_drdy    = !word_vld_q || (c_drdy && last_hit);
        word_xfer = p_srdy && p_drdy;

        c_srdy = word_vld_q;
        c_data = shifted[PFW_SZ-1 -: 8];
        // An end code outranks SOP so a one-byte packet is marked only as its end.
        if (last_hit && final_word)
            c_code = hold_code_q;
        else if ((idx_q == 3'd0) && first_q)
            c_code = PCC_SOP;
        else
            c_code = PCC_DATA;
    end

    always_comb begin
        hold_data_d = hold_data_q;
        hold_code_d = hold_code_q;
        last_idx_d  = last_idx_q;
        word_vld_d  = word_vld_q;
        idx_d       = idx_q;
        in_pkt_d    = in_pkt_q;
        first_d     = first_q;

        if (word_vld_q && c_drdy) begin
            if (last_hit)
                word_vld_d = 1'b0;
            else
                idx_d = idx_q + 3'd1;
        end

        // A word load overrides the final-byte retire so the stream has no bubble.
        if (word_xfer) begin
            hold_data_d = p_data;
            word_vld_d  = 1'b1;
            idx_d       = 3'd0;
            first_d     = !in_pkt_q;
            if ((p_code == PCC_DATA) || (p_code == PCC_SOP)) begin
                hold_code_d = PCC_DATA;
                last_idx_d  = 3'd7;
                in_pkt_d    = 1'b1;
            end else begin
                hold_code_d = p_code;
                last_idx_d  = (p_vbytes == 3'd0) ? 3'd7 : p_vbytes - 3'd1;
                in_pkt_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data_q <= '0;
            hold_code_q <= PCC_DATA;
            last_idx_q  <= 3'd0;
            word_vld_q  <= 1'b0;
            idx_q       <= 3'd0;
            in_pkt_q    <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_code_q <= hold_code_d;
            last_idx_q  <= last_idx_d;
            word_vld_q  <= word_vld_d;
            idx_q       <= idx_d;
            in_pkt_q    <= in_pkt_d;
            first_q     <= first_d;
        end
    end

endmodule
